// File: rtl/ssd_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : ssd_scan_driver
//  Function : N-digit seven-segment scan driver with binary-to-BCD conversion.
//             Shows a loaded binary value in hex or decimal form. Anodes and
//             cathodes are active low and time-multiplexed one digit at a time.
//  Options  : define LEADING_ZERO_BLANK_EN to blank leading zero digits.
//  Revision : 1.0  initial release
// ============================================================================
module ssd_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int BIN_W      = 16,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  ClkPort,
  input  logic                  Reset,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  load,
  input  logic                  dec_mode,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  busy,
  output logic                  ovf,
  output logic [NUM_DIGITS-1:0] An,
  output logic [7:0]            Cath
);

  localparam int c_DW = 4 * NUM_DIGITS;
  localparam int c_IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_PW = $clog2(SCAN_DIV);
  localparam int c_CW = $clog2(BIN_W) + 1;

  localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(NUM_DIGITS - 1);
  localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(SCAN_DIV - 1);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(BIN_W - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_start_dec;
  logic              w_load_hex;
  logic              w_conv_last;

  logic [BIN_W-1:0]  r_bin;
  logic [c_DW-1:0]   r_bcd;
  logic [c_CW-1:0]   r_cnt;
  logic              r_ovf_acc;
  logic [c_DW-1:0]   r_disp;
  logic              r_ovf;

  logic [c_DW-1:0]   w_bcd_adj;
  logic [c_DW-1:0]   w_bcd_shift;
  logic              w_shift_out;
  logic [c_DW-1:0]   w_hex_val;
  logic              w_hex_ovf;

  logic [c_PW-1:0]   r_pre;
  logic [c_IW-1:0]   r_idx;
  logic [3:0]        w_nib;
  logic [7:0]        w_seg;
  logic [NUM_DIGITS-1:0] w_an_nxt;
  logic [7:0]        w_cath_nxt;
  logic [NUM_DIGITS-1:0] r_an;
  logic [7:0]        r_cath;

  // Segment pattern per nibble, bit7..bit0 = Ca..Cg,Dp, 0 = lit, Dp off.
  function automatic logic [7:0] f_font(input logic [3:0] n);
    case (n)
      4'h0:    f_font = 8'h03;
      4'h1:    f_font = 8'h9F;
      4'h2:    f_font = 8'h25;
      4'h3:    f_font = 8'h0D;
      4'h4:    f_font = 8'h99;
      4'h5:    f_font = 8'h49;
      4'h6:    f_font = 8'h41;
      4'h7:    f_font = 8'h1F;
      4'h8:    f_font = 8'h01;
      4'h9:    f_font = 8'h09;
      4'hA:    f_font = 8'h11;
      4'hB:    f_font = 8'hC1;
      4'hC:    f_font = 8'h63;
      4'hD:    f_font = 8'h85;
      4'hE:    f_font = 8'h61;
      default: f_font = 8'h71;
    endcase
  endfunction

  // Hex capture: truncate or zero-extend the input to the display width.
  if (BIN_W > c_DW) begin : g_hex_trunc
    assign w_hex_val = bin_in[c_DW-1:0];
    assign w_hex_ovf = |bin_in[BIN_W-1:c_DW];
  end else if (BIN_W == c_DW) begin : g_hex_exact
    assign w_hex_val = bin_in;
    assign w_hex_ovf = 1'b0;
  end else begin : g_hex_ext
    assign w_hex_val = {{(c_DW - BIN_W){1'b0}}, bin_in};
    assign w_hex_ovf = 1'b0;
  end

  // Conversion state register.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: loads are only honoured in IDLE, so a busy load is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_start_dec = 1'b0;
    w_load_hex  = 1'b0;
    w_conv_last = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          if (dec_mode) begin
            w_start_dec = 1'b1;
            w_state_nxt = S_CONV;
          end else begin
            w_load_hex = 1'b1;
          end
        end
      end
      S_CONV: begin
        if (r_cnt == c_CNT_LAST) begin
          w_conv_last = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next bit.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
    w_bcd_shift = {w_bcd_adj[c_DW-2:0], r_bin[BIN_W-1]};
    w_shift_out = w_bcd_adj[c_DW-1];
  end

  // Conversion datapath; the display only changes on a hex load or the last step.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
      r_disp    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_start_dec) begin
        r_bin     <= bin_in;
        r_bcd     <= '0;
        r_cnt     <= '0;
        r_ovf_acc <= 1'b0;
      end else if (r_state == S_CONV) begin
        r_bin     <= r_bin << 1;
        r_bcd     <= w_bcd_shift;
        r_cnt     <= r_cnt + 1'b1;
        r_ovf_acc <= r_ovf_acc | w_shift_out;
        if (w_conv_last) begin
          r_disp <= w_bcd_shift;
          r_ovf  <= r_ovf_acc | w_shift_out;
        end
      end
      if (w_load_hex) begin
        r_disp <= w_hex_val;
        r_ovf  <= w_hex_ovf;
      end
    end
  end

  // Prescaler and digit index; the index advances when the prescaler wraps.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == c_PRE_LAST) begin
      r_pre <= '0;
      r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_blank;
  logic                  w_upper_zero;

  // A digit is blanked when it and every higher digit are zero; digit 0 never is.
  always_comb begin
    w_blank      = '0;
    w_upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_upper_zero = w_upper_zero & (r_disp[4*k +: 4] == 4'd0);
      w_blank[k]   = w_upper_zero;
    end
  end
`endif

  // Anode/cathode pattern for the digit currently selected by the scan index.
  always_comb begin
    w_nib = r_disp[{r_idx, 2'b00} +: 4];
    w_seg = f_font(w_nib);
`ifdef LEADING_ZERO_BLANK_EN
    if (w_blank[r_idx]) w_seg = 8'hFF;
`endif
    w_an_nxt   = '1;
    w_cath_nxt = 8'hFF;
    if (digit_en[r_idx]) begin
      w_an_nxt[r_idx] = 1'b0;
      w_cath_nxt      = {w_seg[7:1], ~dp_mask[r_idx]};
    end
  end

  // Registered pad drivers so anode and cathode switch on the same edge.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_an   <= '1;
      r_cath <= 8'hFF;
    end else begin
      r_an   <= w_an_nxt;
      r_cath <= w_cath_nxt;
    end
  end

  assign busy = (r_state == S_CONV);
  assign ovf  = r_ovf;
  assign An   = r_an;
  assign Cath = r_cath;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ssd_scan_driver
//  Function : Self-checking bench for ssd_scan_driver. An 8-digit and a 3-digit
//             instance share the stimulus; a short scan divider keeps runs brief.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ssd_scan_driver;

  localparam int c_SD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bin_in;
  logic        load;
  logic        dec_mode;
  logic [7:0]  digit_en;
  logic [7:0]  dp_mask;
  logic        busy, ovf;
  logic [7:0]  an, cath;
  logic        busy3, ovf3;
  logic [2:0]  an3;
  logic [7:0]  cath3;

  int errors = 0;
  int checks = 0;
  logic [31:0] prev_disp;
  logic        prev_ovf;

  always #5 clk = ~clk;

  ssd_scan_driver #(.NUM_DIGITS(8), .BIN_W(16), .SCAN_DIV(c_SD)) u_dut (
    .ClkPort(clk), .Reset(rst), .bin_in(bin_in), .load(load), .dec_mode(dec_mode),
    .digit_en(digit_en), .dp_mask(dp_mask), .busy(busy), .ovf(ovf), .An(an), .Cath(cath)
  );

  ssd_scan_driver #(.NUM_DIGITS(3), .BIN_W(16), .SCAN_DIV(c_SD)) u_dut3 (
    .ClkPort(clk), .Reset(rst), .bin_in(bin_in), .load(load), .dec_mode(dec_mode),
    .digit_en(digit_en[2:0]), .dp_mask(dp_mask[2:0]), .busy(busy3), .ovf(ovf3),
    .An(an3), .Cath(cath3)
  );

  typedef struct {
    logic [15:0] bin;
    logic        dec;
    logic [31:0] disp;
    logic        ovf;
    int          cycles;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 8'h03;  4'h1: font = 8'h9F;  4'h2: font = 8'h25;  4'h3: font = 8'h0D;
      4'h4: font = 8'h99;  4'h5: font = 8'h49;  4'h6: font = 8'h41;  4'h7: font = 8'h1F;
      4'h8: font = 8'h01;  4'h9: font = 8'h09;  4'hA: font = 8'h11;  4'hB: font = 8'hC1;
      4'hC: font = 8'h63;  4'hD: font = 8'h85;  4'hE: font = 8'h61;  default: font = 8'h71;
    endcase
  endfunction

  function automatic logic [7:0] exp_cath(input logic [31:0] disp, input int i,
                                          input logic [7:0] dpm);
    logic [7:0] f;
    f = font(disp[i*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    if (i != 0 && (disp >> (4 * i)) == 32'd0) f = 8'hFF;
`endif
    return {f[7:1], ~dpm[i]};
  endfunction

  // Walk every enabled digit of one instance (sel=1: 3-digit) and check its cathodes.
  task automatic scan_check(input int sel, input logic [31:0] disp, input int nd,
                            input string tag);
    logic [7:0] a, c, want;
    int w;
    @(negedge clk);
    for (int i = 0; i < nd; i++) begin
      if (digit_en[i]) begin
        want = 8'hFF;
        want[i] = 1'b0;
        w = 0;
        a = (sel != 0) ? {5'h1F, an3} : an;
        while (a !== want && w < 80) begin
          @(negedge clk);
          w++;
          a = (sel != 0) ? {5'h1F, an3} : an;
        end
        c = (sel != 0) ? cath3 : cath;
        if (w >= 80) begin
          checks++;
          errors++;
          $display("FAIL %s digit%0d timeout: An=%h never reached %h", tag, i, a, want);
        end else begin
          chk($sformatf("%s digit%0d Cath", tag, i), {24'd0, c}, {24'd0, exp_cath(disp, i, dp_mask)});
        end
      end
    end
  endtask

  // Issue a one-cycle load and wait (bounded) for the 8-digit instance to go idle.
  task automatic load_wait(input logic [15:0] b, input logic d, output int n);
    @(negedge clk);
    bin_in = b; dec_mode = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Apply one table vector, checking the old display and ovf hold during conversion.
  task automatic run_vec(input int k);
    int n;
    string tag;
    tag = $sformatf("vec%0d", k);
    @(negedge clk);
    bin_in = vecs[k].bin; dec_mode = vecs[k].dec; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      for (int i = 0; i < 8; i++) begin
        if (an[i] === 1'b0)
          chk($sformatf("%s hold digit%0d", tag, i), {24'd0, cath},
              {24'd0, exp_cath(prev_disp, i, dp_mask)});
      end
      chk({tag, " hold ovf"}, {31'd0, ovf}, {31'd0, prev_ovf});
      n++;
      @(negedge clk);
    end
    chk({tag, " busy cycles"}, n, vecs[k].cycles);
    chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, vecs[k].ovf});
    scan_check(0, vecs[k].disp, 8, tag);
    prev_disp = vecs[k].disp;
    prev_ovf  = vecs[k].ovf;
  endtask

  initial begin
    int n, cnt, bad_hi, off_cnt, off_bad;

    vecs[0] = '{bin: 16'hBEEF, dec: 1'b0, disp: 32'h0000BEEF, ovf: 1'b0, cycles: 0};
    vecs[1] = '{bin: 16'd65535, dec: 1'b1, disp: 32'h00065535, ovf: 1'b0, cycles: 16};
    vecs[2] = '{bin: 16'd0,     dec: 1'b1, disp: 32'h00000000, ovf: 1'b0, cycles: 16};
    vecs[3] = '{bin: 16'h1234,  dec: 1'b0, disp: 32'h00001234, ovf: 1'b0, cycles: 0};
    vecs[4] = '{bin: 16'd9999,  dec: 1'b1, disp: 32'h00009999, ovf: 1'b0, cycles: 16};
    vecs[5] = '{bin: 16'd100,   dec: 1'b1, disp: 32'h00000100, ovf: 1'b0, cycles: 16};
    vecs[6] = '{bin: 16'h0000,  dec: 1'b0, disp: 32'h00000000, ovf: 1'b0, cycles: 0};

    rst = 1'b1; bin_in = '0; load = 1'b0; dec_mode = 1'b0;
    digit_en = 8'hFF; dp_mask = 8'h00;
    prev_disp = '0; prev_ovf = 1'b0;

    // Reset held: pads dark, idle.
    repeat (3) @(negedge clk);
    chk("reset An", {24'd0, an}, 32'hFF);
    chk("reset Cath", {24'd0, cath}, 32'hFF);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset ovf", {31'd0, ovf}, 32'd0);

    // Release: digit 0 drives one edge later and stays for SCAN_DIV cycles.
    rst = 1'b0;
    @(negedge clk);
    chk("first An", {24'd0, an}, 32'hFE);
    chk("first Cath", {24'd0, cath}, {24'd0, exp_cath(32'd0, 0, 8'h00)});
    cnt = 1;
    @(negedge clk);
    while (an === 8'hFE && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("digit0 slot length", cnt, c_SD);
    chk("second An", {24'd0, an}, 32'hFD);

    for (int k = 0; k < 7; k++) run_vec(k);

    // Decimal 1234 into 3 digits overflows; a load during conversion is ignored.
    @(negedge clk);
    bin_in = 16'd1234; dec_mode = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy3 === 1'b1 && n < 100) begin
      if (n == 5) begin
        bin_in = 16'd42; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    load = 1'b0;
    chk("dut3 busy cycles", n, 16);
    chk("dut3 dec ovf", {31'd0, ovf3}, 32'd1);
    chk("dut8 dec1234 ovf", {31'd0, ovf}, 32'd0);
    scan_check(1, 32'h234, 3, "dut3 dec1234");
    scan_check(0, 32'h1234, 8, "dut8 dec1234");

    // Hex truncation on the 3-digit instance.
    load_wait(16'h1234, 1'b0, n);
    chk("dut3 hex ovf set", {31'd0, ovf3}, 32'd1);
    scan_check(1, 32'h234, 3, "dut3 hex1234");
    load_wait(16'h0FFF, 1'b0, n);
    chk("dut3 hex ovf clear", {31'd0, ovf3}, 32'd0);
    scan_check(1, 32'hFFF, 3, "dut3 hex0FFF");

    // Partial enable with a decimal point on digit 0.
    digit_en = 8'h0F; dp_mask = 8'h01;
    load_wait(16'h0012, 1'b0, n);
    scan_check(0, 32'h12, 8, "en0F");
    bad_hi = 0; off_cnt = 0; off_bad = 0;
    for (int t = 0; t < 8 * c_SD; t++) begin
      @(negedge clk);
      if (an[7:4] !== 4'hF) bad_hi++;
      if (an === 8'hFF) begin
        off_cnt++;
        if (cath !== 8'hFF) off_bad++;
      end
    end
    chk("en0F An[7:4] high", bad_hi, 0);
    chk("en0F disabled slots", off_cnt, 4 * c_SD);
    chk("en0F disabled Cath", off_bad, 0);
    digit_en = 8'hFF; dp_mask = 8'h00;

    // Reset during conversion aborts it and clears both displays.
    load_wait(16'hF123, 1'b0, n);
    chk("dut3 pre-reset ovf", {31'd0, ovf3}, 32'd1);
    @(negedge clk);
    bin_in = 16'd65535; dec_mode = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    chk("midconv busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort busy3", {31'd0, busy3}, 32'd0);
    chk("abort ovf3", {31'd0, ovf3}, 32'd0);
    chk("abort An", {24'd0, an}, 32'hFF);
    chk("abort Cath", {24'd0, cath}, 32'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    scan_check(0, 32'h0, 8, "post-abort dut8");
    scan_check(1, 32'h0, 3, "post-abort dut3");
    load_wait(16'd4095, 1'b1, n);
    chk("reconv busy cycles", n, 16);
    chk("reconv ovf", {31'd0, ovf}, 32'd0);
    chk("reconv ovf3", {31'd0, ovf3}, 32'd1);
    scan_check(0, 32'h4095, 8, "reconv dut8");
    scan_check(1, 32'h095, 3, "reconv dut3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
